// File: rtl/ram_port_arbiter.sv
// Fixed-priority arbiter sharing the block RAM data port between M0 (LSU) and M1 (loader/debug).
// Define ARB_STARVE_GUARD_EN to enable the M1 anti-starvation guard.
module ram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 31,
  parameter int unsigned DATA_WIDTH     = 31,
  parameter int unsigned WORD_ADDR_BITS = 12,
  parameter int unsigned LOCK_MAX       = 16,
  parameter int unsigned STARVE_MAX     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic                      i_m0_req,
  input  logic                      i_m1_req,
  input  logic                      i_m0_we,
  input  logic                      i_m1_we,
  input  logic [ADDR_WIDTH:0]       i_m0_addr,
  input  logic [ADDR_WIDTH:0]       i_m1_addr,
  input  logic [3:0]                i_m0_be,
  input  logic [3:0]                i_m1_be,
  input  logic [DATA_WIDTH:0]       i_m0_wdata,
  input  logic [DATA_WIDTH:0]       i_m1_wdata,
  input  logic                      i_m1_lock,
  output logic                      o_m0_gnt,
  output logic                      o_m1_gnt,
  output logic                      o_m0_rvalid,
  output logic                      o_m1_rvalid,
  output logic [DATA_WIDTH:0]       o_m0_rdata,
  output logic [DATA_WIDTH:0]       o_m1_rdata,
  output logic                      o_ram_read_req,
  output logic [WORD_ADDR_BITS-1:0] o_ram_read_addr,
  output logic                      o_ram_write_enable,
  output logic [3:0]                o_ram_byte_enable,
  output logic [WORD_ADDR_BITS-1:0] o_ram_write_addr,
  output logic [DATA_WIDTH:0]       o_ram_write_data,
  input  logic [DATA_WIDTH:0]       i_ram_rdata
);

  localparam int unsigned LCW = $clog2(LOCK_MAX + 1);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_M1_LOCK = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [LCW-1:0]           lock_cnt_q, lock_cnt_d;
  logic                     relock_blk_q, relock_blk_d;
  logic                     m0_rvalid_q, m0_rvalid_d;
  logic                     m1_rvalid_q, m1_rvalid_d;
  logic                     en;
  logic                     m1_pri;
  logic                     sel_m1;
  logic                     m0_gnt, m1_gnt;
  logic [WORD_ADDR_BITS-1:0] word_sel;
  logic                     unused_addr_bits;

  assign en = clk_en & ~rst;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned SCW = $clog2(STARVE_MAX + 1);

  logic [SCW-1:0] starve_cnt_q, starve_cnt_d;

  // M1 wins the next grant once it has waited STARVE_MAX enabled cycles behind M0
  assign m1_pri = (starve_cnt_q == SCW'(STARVE_MAX));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (clk_en) begin
      if (m1_gnt || !i_m1_req) begin
        starve_cnt_d = '0;
      end else if (m0_gnt && (starve_cnt_q != SCW'(STARVE_MAX))) begin
        starve_cnt_d = starve_cnt_q + SCW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  logic unused_starve_cfg;

  assign m1_pri            = 1'b0;
  assign unused_starve_cfg = (STARVE_MAX == 0);
`endif

  // Master selection: M1 owns the port while locked, otherwise M0 first
  always_comb begin
    sel_m1 = 1'b0;
    if (state_q == S_M1_LOCK) begin
      sel_m1 = 1'b1;
    end else begin
      sel_m1 = (m1_pri && i_m1_req) || !i_m0_req;
    end
  end

  assign m0_gnt = en & i_m0_req & ~sel_m1;
  assign m1_gnt = en & i_m1_req & sel_m1;

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    relock_blk_d = relock_blk_q;
    if (clk_en) begin
      if (m0_gnt || !i_m0_req) begin
        relock_blk_d = 1'b0;
      end
      if (state_q == S_IDLE) begin
        if (m1_gnt && i_m1_lock && !relock_blk_q) begin
          state_d    = S_M1_LOCK;
          lock_cnt_d = LCW'(1);
        end
      end else begin
        if (m1_gnt) begin
          if (!i_m1_lock) begin
            state_d    = S_IDLE;
            lock_cnt_d = '0;
          end else if (lock_cnt_q >= LCW'(LOCK_MAX - 1)) begin
            // forced release; M0 must get a turn before M1 may lock again
            state_d      = S_IDLE;
            lock_cnt_d   = '0;
            relock_blk_d = 1'b1;
          end else begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
          end
        end else if (!i_m1_req && !i_m1_lock) begin
          state_d    = S_IDLE;
          lock_cnt_d = '0;
        end
      end
    end
  end

  // Read-valid tracks read grants of the previous enabled cycle; holds while disabled
  always_comb begin
    m0_rvalid_d = m0_rvalid_q;
    m1_rvalid_d = m1_rvalid_q;
    if (clk_en) begin
      m0_rvalid_d = m0_gnt & ~i_m0_we;
      m1_rvalid_d = m1_gnt & ~i_m1_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lock_cnt_q   <= '0;
      relock_blk_q <= 1'b0;
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      relock_blk_q <= relock_blk_d;
      m0_rvalid_q  <= m0_rvalid_d;
      m1_rvalid_q  <= m1_rvalid_d;
    end
  end

  assign word_sel = sel_m1 ? i_m1_addr[WORD_ADDR_BITS+1:2] : i_m0_addr[WORD_ADDR_BITS+1:2];

  assign o_m0_gnt           = m0_gnt;
  assign o_m1_gnt           = m1_gnt;
  assign o_ram_read_req     = (m0_gnt & ~i_m0_we) | (m1_gnt & ~i_m1_we);
  assign o_ram_write_enable = (m0_gnt & i_m0_we) | (m1_gnt & i_m1_we);
  assign o_ram_byte_enable  = (m0_gnt & i_m0_we) ? i_m0_be :
                              (m1_gnt & i_m1_we) ? i_m1_be : 4'b0000;
  assign o_ram_read_addr    = word_sel;
  assign o_ram_write_addr   = word_sel;
  assign o_ram_write_data   = sel_m1 ? i_m1_wdata : i_m0_wdata;

  assign o_m0_rvalid = m0_rvalid_q;
  assign o_m1_rvalid = m1_rvalid_q;
  assign o_m0_rdata  = m0_rvalid_q ? i_ram_rdata : '0;
  assign o_m1_rdata  = m1_rvalid_q ? i_ram_rdata : '0;

  assign unused_addr_bits = ^{i_m0_addr[1:0], i_m0_addr[ADDR_WIDTH:WORD_ADDR_BITS+2],
                              i_m1_addr[1:0], i_m1_addr[ADDR_WIDTH:WORD_ADDR_BITS+2]};

endmodule
